// File: rtl/hi_trace_ctrl_pkg.sv
// Shared constants for the HF trace capture sequencer: major modes, buffer geometry, FSM states.
package hi_trace_ctrl_pkg;

    localparam logic [2:0] FPGA_MAJOR_MODE_HF_READER    = 3'd0;
    localparam logic [2:0] FPGA_MAJOR_MODE_HF_GET_TRACE = 3'd5;
    localparam logic [2:0] FPGA_MAJOR_MODE_OFF          = 3'd7;

    localparam int unsigned TRACE_DEPTH      = 3072;
    localparam int unsigned TRACE_SAMPLE_DIV = 8;
    localparam int unsigned TRACE_IDX_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } trace_state_e;

endpackage

// File: rtl/hi_trace_tickgen.sv
// Free-running sample-slot divider; sample_tick_o marks the cycle in which the divider is 0.
module hi_trace_tickgen
    import hi_trace_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = TRACE_SAMPLE_DIV
) (
    input  logic ck_1356megb,
    input  logic rst_n,
    output logic sample_tick_o
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    // Next divider value; the tick is registered so it is high exactly while the divider reads 0.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == '0);
    end

    // Divider and tick registers on the HF clock falling edge.
    always_ff @(negedge ck_1356megb or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign sample_tick_o = tick_q;

endmodule

// File: rtl/hi_trace_ctrl.sv
// Capture sequencer for the HF ADC trace buffer: pre-trigger fill, threshold trigger,
// post-trigger window, then freeze the buffer and hold the trigger index for readout.
module hi_trace_ctrl
    import hi_trace_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH      = TRACE_DEPTH,
    parameter int unsigned SAMPLE_DIV = TRACE_SAMPLE_DIV,
    parameter int unsigned IDX_W      = TRACE_IDX_W
) (
    input  logic             ck_1356megb,
    input  logic             rst_n,
    input  logic [2:0]       major_mode,
    input  logic             arm,
    input  logic [7:0]       threshold,
    input  logic [IDX_W-1:0] pre_len,
    input  logic [IDX_W-1:0] post_len,
    input  logic [7:0]       adc_d,
    output logic             trace_enable,
    output logic             sample_tick,
    output logic             triggered,
    output logic             done,
    output logic [IDX_W-1:0] trig_index,
    output logic [2:0]       state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    trace_state_e     state_q, state_d;
    logic             arm_q;
    logic             te_q, te_d;
    logic             triggered_q, triggered_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] trig_idx_q, trig_idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0] post_cnt_q, post_cnt_d;

    logic             tick;
    logic             arm_rise;
    logic             mode_off;
    logic             mode_get;
    logic             stored_tick;
    logic [IDX_W-1:0] pre_eff;
    logic [IDX_W-1:0] post_room;
    logic [IDX_W-1:0] post_eff;

    hi_trace_tickgen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tickgen (
        .ck_1356megb   (ck_1356megb),
        .rst_n         (rst_n),
        .sample_tick_o (tick)
    );

    // Window lengths clamped so pre + trigger + post never exceeds the buffer.
    assign pre_eff   = (pre_len > LAST_IDX) ? LAST_IDX : pre_len;
    assign post_room = LAST_IDX - pre_eff;
    assign post_eff  = (post_len > post_room) ? post_room : post_len;

    assign arm_rise    = arm & ~arm_q;
    assign mode_off    = (major_mode == FPGA_MAJOR_MODE_OFF);
    assign mode_get    = (major_mode == FPGA_MAJOR_MODE_HF_GET_TRACE);
    assign stored_tick = tick & te_q;

    // Next-state and datapath update; GET_TRACE freezes everything, OFF aborts to IDLE.
    always_comb begin
        state_d     = state_q;
        te_d        = 1'b0;
        triggered_d = triggered_q;
        done_d      = done_q;
        trig_idx_d  = trig_idx_q;
        wr_idx_d    = wr_idx_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;

        if (mode_get) begin
            te_d = 1'b0;
        end else if (mode_off) begin
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
            done_d      = 1'b0;
        end else begin
            if (stored_tick) begin
                wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    triggered_d = 1'b0;
                    done_d      = 1'b0;
                    if (arm_rise) begin
                        state_d = ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (!arm) begin
                        state_d = ST_IDLE;
                    end else if (pre_cnt_q == pre_eff) begin
                        state_d = ST_WAIT;
                    end else if (stored_tick) begin
                        pre_cnt_d = pre_cnt_q + IDX_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!arm) begin
                        state_d = ST_IDLE;
                    end else if (tick && (adc_d >= threshold)) begin
                        trig_idx_d  = wr_idx_q;
                        triggered_d = 1'b1;
                        post_cnt_d  = '0;
                        if (post_eff == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (!arm) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        if ((post_cnt_q + IDX_W'(1)) == post_eff) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            post_cnt_d = post_cnt_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (arm_rise) begin
                        state_d = ST_PRE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Aborts drop the capture flags; trig_idx is kept for readout.
            if (state_d == ST_IDLE) begin
                triggered_d = 1'b0;
                done_d      = 1'b0;
            end

            // A fresh capture restarts the buffer from index 0.
            if ((state_d == ST_PRE) && (state_q != ST_PRE)) begin
                wr_idx_d    = '0;
                pre_cnt_d   = '0;
                triggered_d = 1'b0;
                done_d      = 1'b0;
            end

            // Write enable follows the current state one cycle late so the final POST tick still stores.
            te_d = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
        end
    end

    // State and datapath registers on the HF clock falling edge, matching the trace buffer.
    always_ff @(negedge ck_1356megb or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            arm_q       <= 1'b0;
            te_q        <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            trig_idx_q  <= '0;
            wr_idx_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm;
            te_q        <= te_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
            trig_idx_q  <= trig_idx_d;
            wr_idx_q    <= wr_idx_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
        end
    end

    assign trace_enable = te_q;
    assign sample_tick  = tick;
    assign triggered    = triggered_q;
    assign done         = done_q;
    assign trig_index   = trig_idx_q;
    assign state        = state_q;

endmodule

// File: tb/tb_hi_trace_ctrl.sv
// Scoreboard bench for hi_trace_ctrl: stimulus queues expected capture results,
// a monitor checks each completion (done rising) against the queue.
module tb_hi_trace_ctrl;
    import hi_trace_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  major_mode;
    logic        arm;
    logic [7:0]  threshold;
    logic [11:0] pre_len;
    logic [11:0] post_len;
    logic [7:0]  adc_d;
    logic        trace_enable;
    logic        sample_tick;
    logic        triggered;
    logic        done;
    logic [11:0] trig_index;
    logic [2:0]  state;

    typedef struct {
        int trig;
        int post;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   post_ticks = 0;
    bit   te_pending = 1'b0;
    bit   done_p = 1'b0;
    bit   trig_p = 1'b0;
    exp_t mon_e;

    hi_trace_ctrl dut (
        .ck_1356megb  (clk),
        .rst_n        (rst_n),
        .major_mode   (major_mode),
        .arm          (arm),
        .threshold    (threshold),
        .pre_len      (pre_len),
        .post_len     (post_len),
        .adc_d        (adc_d),
        .trace_enable (trace_enable),
        .sample_tick  (sample_tick),
        .triggered    (triggered),
        .done         (done),
        .trig_index   (trig_index),
        .state        (state)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT, expected event", name);
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            if (sample_tick === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_ticks(input int n);
        bit ok;
        for (int k = 0; k < n; k++) begin
            wait_tick(ok);
            if (!ok) begin
                timeout("sample_tick");
                return;
            end
        end
    endtask

    // Drop arm, then raise it on a tick-visible cycle so tick numbering is exact.
    task automatic arm_at_tick();
        bit ok;
        arm = 1'b0;
        repeat (2) @(posedge clk);
        wait_tick(ok);
        if (!ok) timeout("arm_tick");
        arm = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done === 1'b1) return;
        end
        timeout("done");
    endtask

    task automatic wait_triggered(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (triggered === 1'b1) return;
        end
        timeout("triggered");
    endtask

    // Monitor: on each completion pop the expected trigger index and post-window tick count.
    initial begin
        forever begin
            @(posedge clk);
            if (te_pending) begin
                te_pending = 1'b0;
                chk("te_off_after_done", 32'(trace_enable), 32'd0);
            end
            if (triggered && !trig_p) begin
                post_ticks = 0;
            end else if (triggered && !done && sample_tick) begin
                post_ticks++;
            end
            if (done && !done_p) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected_done: done rose with trig_index %0d, expected no completion", trig_index);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_trig_index", 32'(trig_index), 32'(mon_e.trig));
                    chk("sb_post_ticks", 32'(post_ticks), 32'(mon_e.post));
                    chk("sb_state_done", 32'(state), 32'(ST_DONE));
                    chk("sb_triggered", 32'(triggered), 32'd1);
                    te_pending = 1'b1;
                end
            end
            done_p = done;
            trig_p = triggered;
        end
    end

    // Directed stimulus.
    initial begin
        exp_t e;
        rst_n      = 1'b0;
        major_mode = FPGA_MAJOR_MODE_HF_READER;
        arm        = 1'b0;
        threshold  = 8'h00;
        pre_len    = 12'd0;
        post_len   = 12'd0;
        adc_d      = 8'h00;
        repeat (3) @(posedge clk);
        chk("rst_trace_enable", 32'(trace_enable), 32'd0);
        chk("rst_sample_tick", 32'(sample_tick), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_trig_index", 32'(trig_index), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;

        // Basic capture: ticks 1..16 fill PRE (idx 0..15), tick 40 triggers at idx 39.
        pre_len = 12'd16; post_len = 12'd32; threshold = 8'h80; adc_d = 8'h10;
        e.trig = 39; e.post = 32; sb_q.push_back(e);
        arm_at_tick();
        wait_ticks(40);
        adc_d = 8'h90;
        wait_done(600);

        // GET_TRACE freezes the finished capture; OFF then aborts but keeps trig_index.
        major_mode = FPGA_MAJOR_MODE_HF_GET_TRACE;
        repeat (2) @(posedge clk);
        chk("get_done", 32'(done), 32'd1);
        chk("get_trig_index", 32'(trig_index), 32'd39);
        chk("get_trace_enable", 32'(trace_enable), 32'd0);
        chk("get_state", 32'(state), 32'd4);
        major_mode = FPGA_MAJOR_MODE_OFF;
        @(posedge clk);
        chk("off_done", 32'(done), 32'd0);
        chk("off_state", 32'(state), 32'd0);
        chk("off_trig_index", 32'(trig_index), 32'd39);
        chk("off_triggered", 32'(triggered), 32'd0);
        major_mode = FPGA_MAJOR_MODE_HF_READER;

        // Abort in WAIT, then re-arm.
        pre_len = 12'd16; post_len = 12'd8; threshold = 8'hFF; adc_d = 8'h10;
        arm_at_tick();
        wait_ticks(20);
        chk("abort_in_wait", 32'(state), 32'd2);
        chk("abort_te_on", 32'(trace_enable), 32'd1);
        arm = 1'b0;
        @(posedge clk);
        chk("abort_idle", 32'(state), 32'd0);
        @(posedge clk);
        chk("abort_te_off", 32'(trace_enable), 32'd0);
        chk("abort_trig_kept", 32'(trig_index), 32'd39);
        arm = 1'b1;
        @(posedge clk);
        chk("rearm_pre", 32'(state), 32'd1);
        chk("rearm_triggered", 32'(triggered), 32'd0);
        chk("rearm_wr_idx", 32'(dut.wr_idx_q), 32'd0);

        // Zero windows, threshold 0: first WAIT tick triggers at idx 0 and completes at once.
        pre_len = 12'd0; post_len = 12'd0; threshold = 8'h00;
        e.trig = 0; e.post = 0; sb_q.push_back(e);
        arm_at_tick();
        wait_done(100);

        // Clamp: pre 3071, post 0; trigger lands on the last index and wr_idx wraps to 0.
        pre_len = 12'd4095; post_len = 12'd4095; threshold = 8'h00;
        e.trig = 3071; e.post = 0; sb_q.push_back(e);
        arm_at_tick();
        wait_done(30000);
        chk("clamp_wr_wrap", 32'(dut.wr_idx_q), 32'd0);

        // Asynchronous reset mid-POST: trigger at idx 4, then reset between clock edges.
        pre_len = 12'd4; post_len = 12'd100; threshold = 8'h00;
        arm_at_tick();
        wait_triggered(200);
        @(posedge clk);
        chk("post_state", 32'(state), 32'd3);
        chk("post_trig_index", 32'(trig_index), 32'd4);
        chk("post_te_on", 32'(trace_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_trace_enable", 32'(trace_enable), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_trig_index", 32'(trig_index), 32'd0);
        chk("arst_triggered", 32'(triggered), 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
